// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - IF/MEM request ports and shared SRAM-like bus bundle

interface mem_bus_arbiter_if;
  // instruction-fetch port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  // data-access port
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  // shared external bus
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  // arbiter view
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_data_ok, data_rdata, data_data_ok,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, busy
  );

  // requester / memory-model view
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_data_ok, data_rdata, data_data_ok,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding inst/data arbiter onto a split-handshake bus

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  mem_bus_arbiter_if.slave mif
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       inst_elig;
  logic       data_elig;
  logic       grant_data;
  logic       grant_inst;

  assign mif.busy = (state != IDLE);

  // Eligibility masks the request still held during its own completion pulse;
  // data wins unless inst has already lost LIMIT times in a row.
  always_comb begin
    inst_elig  = mif.inst_req && !mif.inst_data_ok;
    data_elig  = mif.data_req && !mif.data_data_ok;
    grant_data = data_elig && (!inst_elig || (starve_cnt < LIMIT));
    grant_inst = inst_elig && !grant_data;
  end

  // Transaction FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      owner            <= OWN_INST;
      starve_cnt       <= 4'd0;
      mif.bus_req      <= 1'b0;
      mif.bus_wr       <= 1'b0;
      mif.bus_size     <= 2'd0;
      mif.bus_addr     <= 32'd0;
      mif.bus_wdata    <= 32'd0;
      mif.inst_rdata   <= 32'd0;
      mif.inst_data_ok <= 1'b0;
      mif.data_rdata   <= 32'd0;
      mif.data_data_ok <= 1'b0;
    end else begin
      mif.inst_data_ok <= 1'b0;
      mif.data_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            owner         <= OWN_DATA;
            mif.bus_req   <= 1'b1;
            mif.bus_wr    <= mif.data_wr;
            mif.bus_size  <= mif.data_size;
            mif.bus_addr  <= mif.data_addr;
            mif.bus_wdata <= mif.data_wdata;
            state         <= ADDR;
            // grant_data with inst eligible implies starve_cnt < LIMIT, so no wrap
            if (inst_elig) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (grant_inst) begin
            owner         <= OWN_INST;
            mif.bus_req   <= 1'b1;
            mif.bus_wr    <= 1'b0;
            mif.bus_size  <= 2'd2;
            mif.bus_addr  <= mif.inst_addr;
            mif.bus_wdata <= 32'd0;
            state         <= ADDR;
            starve_cnt    <= 4'd0;
          end
        end
        ADDR: begin
          if (mif.bus_addr_ok) begin
            mif.bus_req <= 1'b0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (mif.bus_data_ok) begin
            if (owner == OWN_INST) begin
              mif.inst_rdata   <= mif.bus_rdata;
              mif.inst_data_ok <= 1'b1;
            end else begin
              mif.data_rdata   <= mif.bus_rdata;
              mif.data_data_ok <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
